// File: rtl/pellet_eat_ctrl_pkg.sv
// rtl/pellet_eat_ctrl_pkg.sv - shared constants, FSM states and helpers for the pellet eat controller
package pellet_eat_ctrl_pkg;

  localparam int MAP_W            = 5;
  localparam int REMAIN_W         = 9;
  localparam int PELLET_TOTAL_DEF = 220;
  localparam int POINTS_DEF       = 10;
  localparam int SCORE_W_DEF      = 16;
  localparam int LEVEL_W_DEF      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_REFILL = 3'd4
  } state_e;

  // Pellet counter never wraps below zero, even if a stray clear slips through.
  function automatic logic [REMAIN_W-1:0] dec_floor(input logic [REMAIN_W-1:0] v);
    return (v == '0) ? '0 : v - REMAIN_W'(1);
  endfunction

endpackage

// File: rtl/pellet_eat_ctrl_if.sv
// rtl/pellet_eat_ctrl_if.sv - tile handshake between player movement and the pellet eat controller
interface pellet_eat_ctrl_if;
  import pellet_eat_ctrl_pkg::*;

  logic             tile_valid;
  logic             tile_ready;
  logic [MAP_W-1:0] tile_x;
  logic [MAP_W-1:0] tile_y;

  modport master (output tile_valid, output tile_x, output tile_y, input tile_ready);
  modport slave  (input tile_valid, input tile_x, input tile_y, output tile_ready);

endinterface

// File: rtl/pellet_eat_ctrl_score_sat_add.sv
// rtl/pellet_eat_ctrl_score_sat_add.sv - saturating score accumulator
module score_sat_add #(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               add_en,
  input  logic [SCORE_W-1:0] amount,
  output logic [SCORE_W-1:0] sum
);

  logic [SCORE_W-1:0] sum_q;
  logic [SCORE_W-1:0] sum_d;
  logic [SCORE_W:0]   wide;

  // Add with one guard bit; a carry out pins the score at all-ones.
  always_comb begin
    wide  = {1'b0, sum_q} + {1'b0, amount};
    sum_d = sum_q;
    if (add_en) begin
      sum_d = wide[SCORE_W] ? '1 : wide[SCORE_W-1:0];
    end
  end

  // Score register, cleared only by system reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/pellet_eat_ctrl.sv
// rtl/pellet_eat_ctrl.sv - pellet lookup/clear FSM with score, remaining and level tracking
module pellet_eat_ctrl
  import pellet_eat_ctrl_pkg::*;
#(
  parameter int PELLET_TOTAL = PELLET_TOTAL_DEF,
  parameter int POINTS       = POINTS_DEF,
  parameter int SCORE_W      = SCORE_W_DEF,
  parameter int LEVEL_W      = LEVEL_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  pellet_eat_ctrl_if.slave    tile_if,
  input  logic                new_level,
  output logic [MAP_W-1:0]    xpos_b,
  output logic [MAP_W-1:0]    ypos_b,
  output logic                clear_b,
  input  logic                out_b,
  output logic                pellet_reset,
  output logic                eaten,
  output logic [SCORE_W-1:0]  score,
  output logic [REMAIN_W-1:0] remaining,
  output logic                level_done,
  output logic [LEVEL_W-1:0]  level
);

  localparam logic [REMAIN_W-1:0] RELOAD    = REMAIN_W'(PELLET_TOTAL);
  localparam logic [SCORE_W-1:0]  POINTS_SW = SCORE_W'(POINTS);

  state_e                state_q, state_d;
  logic [MAP_W-1:0]      xpos_q, xpos_d;
  logic [MAP_W-1:0]      ypos_q, ypos_d;
  logic                  eaten_q, eaten_d;
  logic                  pellet_reset_q, pellet_reset_d;
  logic [REMAIN_W-1:0]   remaining_q, remaining_d;
  logic                  level_done_q, level_done_d;
  logic [LEVEL_W-1:0]    level_q, level_d;

  // Next-state and counter updates; new_level overrides whatever the lookup was doing.
  always_comb begin
    state_d        = state_q;
    xpos_d         = xpos_q;
    ypos_d         = ypos_q;
    remaining_d    = remaining_q;
    level_done_d   = level_done_q;
    level_d        = level_q;

    case (state_q)
      ST_IDLE: begin
        if (tile_if.tile_valid) begin
          xpos_d  = tile_if.tile_x;
          ypos_d  = tile_if.tile_y;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_d = out_b ? ST_CLEAR : ST_IDLE;
      end
      ST_CLEAR: begin
        remaining_d = dec_floor(remaining_q);
        if (remaining_q == REMAIN_W'(1)) begin
          level_done_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      ST_REFILL: begin
        remaining_d  = RELOAD;
        level_done_d = 1'b0;
        level_d      = level_q + LEVEL_W'(1);
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A clear already on the bus still completes; only the next state is redirected.
    if (new_level) begin
      state_d = ST_REFILL;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
    end

    eaten_d        = (state_d == ST_CLEAR);
    pellet_reset_d = (state_d == ST_REFILL);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      xpos_q         <= '0;
      ypos_q         <= '0;
      eaten_q        <= 1'b0;
      pellet_reset_q <= 1'b0;
      remaining_q    <= RELOAD;
      level_done_q   <= 1'b0;
      level_q        <= '0;
    end else begin
      state_q        <= state_d;
      xpos_q         <= xpos_d;
      ypos_q         <= ypos_d;
      eaten_q        <= eaten_d;
      pellet_reset_q <= pellet_reset_d;
      remaining_q    <= remaining_d;
      level_done_q   <= level_done_d;
      level_q        <= level_d;
    end
  end

  score_sat_add #(
    .SCORE_W (SCORE_W)
  ) u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .add_en  (state_q == ST_CLEAR),
    .amount  (POINTS_SW),
    .sum     (score)
  );

  assign tile_if.tile_ready = (state_q == ST_IDLE);
  assign clear_b            = (state_q == ST_CLEAR);
  assign xpos_b             = xpos_q;
  assign ypos_b             = ypos_q;
  assign eaten              = eaten_q;
  assign pellet_reset       = pellet_reset_q;
  assign remaining          = remaining_q;
  assign level_done         = level_done_q;
  assign level              = level_q;

endmodule
